// File: rtl/regfile_wb_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_scoreboard_pkg
//  Description : Shared widths and types for the decode-stage register file
//                and its pending-write scoreboard.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_scoreboard_pkg;

    localparam int REG_DATA_W = 16;  // register width in bits
    localparam int NUM_REGS   = 8;   // architectural registers
    localparam int REG_ADDR_W = 3;   // clog2(NUM_REGS)
    localparam int PEND_W     = 2;   // per-register outstanding-write counter width

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
    typedef logic [PEND_W-1:0]     pend_cnt_t;

    // Counter value at which a register cannot accept another issue.
    localparam pend_cnt_t C_PEND_MAX = '1;

endpackage : regfile_wb_scoreboard_pkg
`default_nettype wire

// File: rtl/regfile_wb_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_scoreboard_if
//  Description : Decode read/issue bus plus write-back bus for the register
//                file. master = decode/write-back side, slave = register file.
//  Signals     : Rx, Ry, use_x, use_y   - read addresses and read-use flags
//                data1, data2           - bypassed read data
//                issue_en, issue_rd     - destination issue from decode
//                stall                  - issue/read must hold
//                wr_en, wr_addr, wr_data- write-back port
//                wb_err                 - sticky write-back protocol error
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_scoreboard_if;
    import regfile_wb_scoreboard_pkg::*;

    reg_addr_t Rx;
    reg_addr_t Ry;
    logic      use_x;
    logic      use_y;
    reg_data_t data1;
    reg_data_t data2;
    logic      issue_en;
    reg_addr_t issue_rd;
    logic      stall;
    logic      wr_en;
    reg_addr_t wr_addr;
    reg_data_t wr_data;
    logic      wb_err;

    modport master (
        output Rx, Ry, use_x, use_y, issue_en, issue_rd, wr_en, wr_addr, wr_data,
        input  data1, data2, stall, wb_err
    );

    modport slave (
        input  Rx, Ry, use_x, use_y, issue_en, issue_rd, wr_en, wr_addr, wr_data,
        output data1, data2, stall, wb_err
    );

endinterface : regfile_wb_scoreboard_if
`default_nettype wire

// File: rtl/regfile_wb_scoreboard_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register pending-write counters, read-after-write hazard
//                detection, full detection, stall and sticky wb_err.
//  Ports       : clk, reset             - clock, synchronous active-high reset
//                i_rx, i_ry, i_use_x/y  - decode read addresses and use flags
//                i_issue_en, i_issue_rd - destination issue from decode
//                i_wr_en, i_wr_addr     - write-back strobe and destination
//                o_stall                - combinational stall to decode
//                o_wb_err               - registered sticky protocol error
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_wb_scoreboard_pkg::*;
(
    input  wire       clk,
    input  wire       reset,
    input  reg_addr_t i_rx,
    input  reg_addr_t i_ry,
    input  wire       i_use_x,
    input  wire       i_use_y,
    input  wire       i_issue_en,
    input  reg_addr_t i_issue_rd,
    input  wire       i_wr_en,
    input  reg_addr_t i_wr_addr,
    output logic      o_stall,
    output logic      o_wb_err
);

    pend_cnt_t r_pend_cnt [NUM_REGS];
    logic      r_wb_err;

    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_underflow;
    pend_cnt_t           w_cnt_x;
    pend_cnt_t           w_cnt_y;
    logic                w_haz_x;
    logic                w_haz_y;
    logic                w_full;
    logic                w_stall;

    assign w_cnt_x = r_pend_cnt[i_rx];
    assign w_cnt_y = r_pend_cnt[i_ry];

    // A single outstanding write that is retiring this cycle is not a hazard:
    // the write-through bypass hands decode the final value.
    assign w_haz_x = i_use_x && (w_cnt_x != '0) &&
                     !((w_cnt_x == pend_cnt_t'(1)) && i_wr_en && (i_wr_addr == i_rx));
    assign w_haz_y = i_use_y && (w_cnt_y != '0) &&
                     !((w_cnt_y == pend_cnt_t'(1)) && i_wr_en && (i_wr_addr == i_ry));

    assign w_full  = i_issue_en && (r_pend_cnt[i_issue_rd] == C_PEND_MAX);
    assign w_stall = w_haz_x || w_haz_y || w_full;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
        assign w_inc[r]       = i_issue_en && !w_stall && (i_issue_rd == REG_ADDR_W'(r));
        assign w_dec[r]       = i_wr_en && (i_wr_addr == REG_ADDR_W'(r));
        // Write-back with nothing outstanding for that register.
        assign w_underflow[r] = w_dec[r] && (r_pend_cnt[r] == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_pend_cnt[r] <= '0;
            end
            r_wb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                // inc and dec together cancel; the full check keeps inc from
                // wrapping and the underflow check keeps dec from wrapping.
                if (w_inc[r] && !w_dec[r]) begin
                    r_pend_cnt[r] <= r_pend_cnt[r] + pend_cnt_t'(1);
                end else if (w_dec[r] && !w_inc[r] && (r_pend_cnt[r] != '0)) begin
                    r_pend_cnt[r] <= r_pend_cnt[r] - pend_cnt_t'(1);
                end
            end
            if (|w_underflow) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign o_stall  = w_stall;
    assign o_wb_err = r_wb_err;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_scoreboard
//  Description : 8 x 16-bit register file with two combinational read ports,
//                write-through bypass from write-back, and a pending-write
//                scoreboard that stalls decode on read-after-write hazards.
//  Ports       : clk   - clock, state updates on rising edge
//                reset - synchronous active-high reset
//                bus   - regfile_wb_scoreboard_if.slave (read, issue,
//                        write-back, stall and wb_err signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scoreboard
    import regfile_wb_scoreboard_pkg::*;
(
    input  wire                       clk,
    input  wire                       reset,
    regfile_wb_scoreboard_if.slave    bus
);

    reg_data_t r_rf [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_rf[r] <= '0;
            end
        end else if (bus.wr_en) begin
            r_rf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Write-through: a write landing this cycle is visible to decode now.
    assign bus.data1 = (bus.wr_en && (bus.wr_addr == bus.Rx)) ? bus.wr_data : r_rf[bus.Rx];
    assign bus.data2 = (bus.wr_en && (bus.wr_addr == bus.Ry)) ? bus.wr_data : r_rf[bus.Ry];

    regfile_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .i_rx       (bus.Rx),
        .i_ry       (bus.Ry),
        .i_use_x    (bus.use_x),
        .i_use_y    (bus.use_y),
        .i_issue_en (bus.issue_en),
        .i_issue_rd (bus.issue_rd),
        .i_wr_en    (bus.wr_en),
        .i_wr_addr  (bus.wr_addr),
        .o_stall    (bus.stall),
        .o_wb_err   (bus.wb_err)
    );

endmodule : regfile_wb_scoreboard
`default_nettype wire

// File: tb/tb_regfile_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_scoreboard
//  Description : Self-checking bench for regfile_wb_scoreboard: a directed
//                vector table for the documented sequences, then random
//                traffic against a behavioural model of the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scoreboard;

    logic clk;
    logic reset;

    regfile_wb_scoreboard_if bus ();

    regfile_wb_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  rx;
        logic [2:0]  ry;
        logic        ux;
        logic        uy;
        logic        ie;
        logic [2:0]  rd;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        chk;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        st;
        logic        er;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    int n_cmp;
    int n_bad;

    // behavioural model state
    logic [15:0] m_rf   [8];
    int          m_pend [8];
    logic        m_err;

    function automatic vec_t v(input logic rst, input int rx, input int ry,
                               input logic ux, input logic uy, input logic ie,
                               input int rd, input logic we, input int wa,
                               input logic [15:0] wd, input logic chk,
                               input logic [15:0] d1, input logic [15:0] d2,
                               input logic st, input logic er);
        vec_t t;
        t.rst = rst; t.rx = 3'(rx); t.ry = 3'(ry); t.ux = ux; t.uy = uy;
        t.ie = ie; t.rd = 3'(rd); t.we = we; t.wa = 3'(wa); t.wd = wd;
        t.chk = chk; t.d1 = d1; t.d2 = d2; t.st = st; t.er = er;
        return t;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset        = t.rst;
        bus.Rx       = t.rx;
        bus.Ry       = t.ry;
        bus.use_x    = t.ux;
        bus.use_y    = t.uy;
        bus.issue_en = t.ie;
        bus.issue_rd = t.rd;
        bus.wr_en    = t.we;
        bus.wr_addr  = t.wa;
        bus.wr_data  = t.wd;
    endtask

    task automatic compare(input string tag, input int idx, input vec_t t);
        check({tag, ".data1"},  idx, bus.data1, t.d1);
        check({tag, ".data2"},  idx, bus.data2, t.d2);
        check({tag, ".stall"},  idx, 16'(bus.stall), 16'(t.st));
        check({tag, ".wb_err"}, idx, 16'(bus.wb_err), 16'(t.er));
    endtask

    // Expected outputs straight from the model's register/count arrays.
    function automatic vec_t model_expect(input vec_t t);
        vec_t e;
        bit   hx, hy, full;
        e = t;
        e.d1 = (t.we && t.wa == t.rx) ? t.wd : m_rf[t.rx];
        e.d2 = (t.we && t.wa == t.ry) ? t.wd : m_rf[t.ry];
        hx   = t.ux && m_pend[t.rx] > 0 && !(m_pend[t.rx] == 1 && t.we && t.wa == t.rx);
        hy   = t.uy && m_pend[t.ry] > 0 && !(m_pend[t.ry] == 1 && t.we && t.wa == t.ry);
        full = t.ie && m_pend[t.rd] == 3;
        e.st = hx || hy || full;
        e.er = m_err;
        return e;
    endfunction

    task automatic model_step(input vec_t t, input logic stalled);
        int delta [8];
        if (t.rst) begin
            for (int i = 0; i < 8; i++) begin
                m_rf[i]   = '0;
                m_pend[i] = 0;
            end
            m_err = 1'b0;
            return;
        end
        for (int i = 0; i < 8; i++) delta[i] = 0;
        if (t.ie && !stalled) delta[t.rd] += 1;
        if (t.we) begin
            if (m_pend[t.wa] == 0) m_err = 1'b1;
            delta[t.wa] -= 1;
            m_rf[t.wa] = t.wd;
        end
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = m_pend[i] + delta[i];
            if (m_pend[i] < 0) m_pend[i] = 0;
        end
    endtask

    initial begin
        vec_t t, e;
        int   wa;
        n_cmp = 0;
        n_bad = 0;

        //              rst rx ry ux uy ie rd we wa wd        chk d1        d2        st er
        tbl[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        tbl[1]  = v(0, 3, 5, 1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0);
        tbl[2]  = v(0, 0, 0, 0, 0, 1, 2, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0);
        tbl[3]  = v(0, 2, 0, 1, 0, 0, 0, 1, 2, 16'hBEEF, 1, 16'hBEEF, 16'h0000, 0, 0);
        tbl[4]  = v(0, 2, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 1, 16'hBEEF, 16'h0000, 0, 0);
        tbl[5]  = v(0, 2, 0, 1, 0, 1, 4, 0, 0, 16'h0000, 1, 16'hBEEF, 16'h0000, 0, 0);
        tbl[6]  = v(0, 4, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 1, 0);
        tbl[7]  = v(0, 4, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 1, 0);
        tbl[8]  = v(0, 4, 0, 1, 0, 0, 0, 1, 4, 16'h0042, 1, 16'h0042, 16'h0000, 0, 0);
        tbl[9]  = v(0, 4, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0042, 16'h0000, 0, 0);
        tbl[10] = v(0, 0, 0, 0, 0, 1, 6, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0);
        tbl[11] = v(0, 0, 0, 0, 0, 1, 6, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0);
        tbl[12] = v(0, 0, 0, 0, 0, 1, 6, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0);
        tbl[13] = v(0, 0, 0, 0, 0, 1, 6, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 1, 0);
        tbl[14] = v(0, 6, 0, 0, 0, 1, 6, 1, 6, 16'h1234, 1, 16'h1234, 16'h0000, 1, 0);
        tbl[15] = v(0, 6, 0, 0, 0, 1, 6, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 0, 0);
        tbl[16] = v(0, 6, 0, 0, 0, 1, 6, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 1, 0);
        tbl[17] = v(0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0);
        tbl[18] = v(0, 0, 1, 0, 0, 1, 1, 1, 1, 16'h1111, 1, 16'h0000, 16'h1111, 0, 0);
        tbl[19] = v(0, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h1111, 16'h0000, 1, 0);
        tbl[20] = v(0, 7, 0, 1, 0, 0, 0, 1, 7, 16'h7777, 1, 16'h7777, 16'h0000, 0, 0);
        tbl[21] = v(0, 7, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h7777, 16'h0000, 0, 1);
        tbl[22] = v(0, 7, 1, 1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h7777, 16'h1111, 1, 1);
        tbl[23] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        tbl[24] = v(0, 7, 2, 1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0);
        tbl[25] = v(0, 6, 1, 0, 1, 1, 6, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0);

        // Directed table: one row per clock, checked just before the edge.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            if (tbl[i].chk) compare("dir", i, tbl[i]);
        end

        // Random traffic against the model; first cycle is a reset so the
        // model and the DUT start from the same known state.
        for (int c = 0; c < 1500; c++) begin
            t.rst = (c == 0) || ($urandom_range(0, 99) == 0);
            t.rx  = 3'($urandom_range(0, 7));
            t.ry  = 3'($urandom_range(0, 7));
            t.ux  = 1'($urandom_range(0, 1));
            t.uy  = 1'($urandom_range(0, 1));
            t.ie  = 1'($urandom_range(0, 1));
            t.rd  = 3'($urandom_range(0, 7));
            t.we  = ($urandom_range(0, 9) < 4);
            wa    = $urandom_range(0, 7);
            // Mostly retire a register that really has a write outstanding.
            if ($urandom_range(0, 19) != 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_pend[wa] == 0) wa = (wa + 1) % 8;
                end
            end
            t.wa  = 3'(wa);
            t.wd  = 16'($urandom);
            t.chk = 1'b1;
            @(negedge clk);
            drive(t);
            #1;
            if (c != 0) begin
                e = model_expect(t);
                compare("rnd", c, e);
                model_step(t, e.st);
            end else begin
                model_step(t, 1'b0);
            end
        end

        @(negedge clk);
        reset        = 1'b0;
        bus.wr_en    = 1'b0;
        bus.issue_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regfile_wb_scoreboard
`default_nettype wire

// File: doc/regfile_wb_scoreboard.md
Name: regfile_wb_scoreboard

Overview:
- Responder side of the decode-stage register read interface: 8 x 16-bit register file.
- Decode presents Rx/Ry addresses; this block returns data1/data2 combinationally, with write-through bypass from the write-back port.
- A per-register pending-write scoreboard reports read-after-write hazards and stalls destination issue from decode.
- Sits between the decode stage (read side, issue side) and the write-back stage (write side).

Parameters:
- DATA_W, 16, register width in bits.
- NREG, 8, number of architectural registers.
- ADDR_W, 3, register address width; equals clog2(NREG).
- PEND_W, 2, pending-write counter width; at most 2^PEND_W-1 writes may be outstanding per register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Rx  in  ADDR_W  read address, port 1.
- Ry  in  ADDR_W  read address, port 2.
- use_x  in  1  decode instruction reads Rx.
- use_y  in  1  decode instruction reads Ry.
- data1  out  DATA_W  contents of [Rx], bypassed.
- data2  out  DATA_W  contents of [Ry], bypassed.
- issue_en  in  1  decode instruction will write a register.
- issue_rd  in  ADDR_W  destination register of the issuing instruction.
- stall  out  1  decode must hold; the issue is not accepted.
- wr_en  in  1  write-back valid.
- wr_addr  in  ADDR_W  write-back destination.
- wr_data  in  DATA_W  write-back value.
- wb_err  out  1  sticky protocol error flag.

Behaviour:
- Storage: rf[0..NREG-1].
  - Reset clears all entries to 0, all pend_cnt to 0, and wb_err to 0.
  - wr_en is ignored during the reset cycle.
- Write: at posedge, if wr_en then rf[wr_addr] <= wr_data.
- Read (combinational, zero latency):
  - data1 = (wr_en && wr_addr==Rx) ? wr_data : rf[Rx].
  - data2 follows the same rule with Ry.
  - Both ports may address the same register, and may equal wr_addr.
- Scoreboard: pend_cnt[r], PEND_W bits each.
  - inc_r = issue_en && !stall && issue_rd==r.
  - dec_r = wr_en && wr_addr==r.
  - inc only: +1. dec only: -1. Both in the same cycle: unchanged.
  - dec while pend_cnt==0 (write-back without a matching issue): counter stays 0, wb_err <= 1.
  - wb_err is sticky until reset.
- Hazard per read port (X shown; Y is identical):
  - haz_x = use_x && pend_cnt[Rx]!=0.
  - Exception: haz_x is cleared when pend_cnt[Rx]==1 && wr_en && wr_addr==Rx, because the bypass supplies the final value.
- Full: full = issue_en && pend_cnt[issue_rd]==max (all ones).
- stall = haz_x || haz_y || full.
  - stall is combinational.
  - While stall=1 the issue has no effect on any counter.
- An instruction that reads and writes the same register (e.g. add r1,r1) resolves the read hazard first. Once stall=0, its issue increments pend_cnt[r1] at that edge.
- Reset asserted mid-operation discards all pending state. In-flight write-backs arriving after reset raise wb_err; they are a flush-ordering bug upstream.
- No internal FSM beyond the counters. Outputs other than wb_err are pure functions of current state and inputs.

Decomposition:
- definesPkg gains:
  - REG_DATA_W=16, NUM_REGS=8, REG_ADDR_W=3, PEND_W=2.
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0]).
  - typedef reg_data_t (logic [REG_DATA_W-1:0]).
- One sub-module: regfile_scoreboard. It holds the pend_cnt array, inc/dec/saturation logic, the hazard/full/stall equations, and wb_err.
- The top level holds storage, write, and the bypass mux.

Test Plan:
- Reset, then Rx=3, Ry=5, use_x=use_y=1, no writes -> data1=0, data2=0, stall=0; wb_err=0.
- wr_en=1, wr_addr=2, wr_data=16'hBEEF with Rx=2 in the same cycle -> data1=16'hBEEF combinationally. Next cycle with wr_en=0 -> data1=16'hBEEF from storage.
- Issue issue_rd=4 (stall=0), then Rx=4, use_x=1 -> stall=1 for 2 cycles. On the cycle wr_en=1, wr_addr=4, wr_data=16'h0042: stall=0 and data1=16'h0042. pend_cnt[4] ends at 0.
- Issue r6 three times -> pend_cnt[6]=3. A fourth issue to r6 -> stall=1 and the count stays 3. A write-back to r6 while issue_rd=6 is held -> count 3->2 at that edge, full clears, stall=0 next cycle. The retried issue at that edge -> count 3 (inc wins at the following edge).
- Issue r1 and write back r1 in the same cycle with pend_cnt[1]=1 -> count stays 1, wb_err=0.
- wr_en=1 to r7 with pend_cnt[7]=0 -> wb_err=1 and rf[7] is written. wb_err stays 1 until reset; reset clears rf, counters and wb_err within one cycle.
